// File: rtl/uart_apb_master.sv
// uart_apb_master: serial-to-APB initiator bridge.
// Receives 8N1 command frames on rx_i ('W' + addr[4] + data[4], or 'R' + addr[4],
// all multi-byte fields LSB first), runs one APB transfer, and answers on tx_o
// with a status byte ('K' ok, 'E' slave error, 'T' timeout) followed, for
// reads, by the 4 captured read-data bytes LSB first.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   rx_i / tx_o             UART serial in / out (idle high)
//   psel_o .. pwdata_o      APB master request
//   prdata_i .. pslverr_i   APB completer response
//   busy_o                  command in progress (first byte .. last response bit)
// Optional feature macro: UART_APB_TIMEOUT_EN aborts an access after 256
// cycles without pready_i.
module uart_apb_master #(
  parameter int ClkFreqHz    = 50_000_000,
  parameter int BaudRate     = 115200,
  parameter int ApbAddrWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_i,
  output logic                    tx_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ApbAddrWidth-1:0] paddr_o,
  output logic [31:0]             pwdata_o,
  input  logic [31:0]             prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  output logic                    busy_o
);
  localparam int Div  = ClkFreqHz / BaudRate;
  localparam int CntW = $clog2(Div + 1);
  localparam logic [CntW-1:0] DivM1  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Div / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_SETUP, S_ACCESS, S_RESP, S_DONE
  } state_t;

  // ---------------- RX ----------------
  logic            rx_s1, rx_s2, rx_d;
  logic            rx_busy, rx_valid, rx_ferr;
  logic [CntW-1:0] rx_cnt;
  logic [3:0]      rx_bit;
  logic [7:0]      rx_sr, rx_byte;

  // rx_cnt counts down to each sample point: half a bit to the start-bit
  // midpoint, then a full bit per data/stop bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_d <= 1'b1;
      rx_busy <= 1'b0; rx_valid <= 1'b0; rx_ferr <= 1'b0;
      rx_cnt <= '0; rx_bit <= '0; rx_sr <= '0; rx_byte <= '0;
    end else begin
      rx_s1    <= rx_i;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_busy) begin
        if (rx_d && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HalfM1;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= DivM1;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;          // false start
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s2) begin
            rx_valid <= 1'b1;
            rx_byte  <= rx_sr;
          end else begin
            rx_ferr  <= 1'b1;
          end
        end else begin
          rx_sr <= {rx_s2, rx_sr[7:1]};
        end
      end
    end
  end

  // ---------------- TX ----------------
  logic            tx_busy, tx_ready, tx_load;
  logic [CntW-1:0] tx_cnt;
  logic [3:0]      tx_bit;
  logic [9:0]      tx_sr;
  logic [7:0]      tx_data;

  // Ready also in the last cycle of a stop bit so frames go back to back.
  assign tx_ready = !tx_busy || (tx_cnt == DivM1 && tx_bit == 4'd9);
  assign tx_o     = tx_sr[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_sr <= '1; tx_busy <= 1'b0; tx_cnt <= '0; tx_bit <= '0;
    end else if (tx_load) begin
      tx_sr   <= {1'b1, tx_data, 1'b0};
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == DivM1) begin
        tx_cnt <= '0;
        tx_sr  <= {1'b1, tx_sr[9:1]};
        tx_bit <= tx_bit + 1'b1;
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- Parser / APB FSM ----------------
  state_t      state, state_n;
  logic [1:0]  byte_cnt, resp_idx;
  logic        is_wr, timeout;
  logic [31:0] addr_sr, wd_sr, rdata_q, addr_nx, wd_nx;

`ifdef UART_APB_TIMEOUT_EN
  logic [7:0] to_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                to_cnt <= '0;
    else if (state != S_ACCESS) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = (state == S_ACCESS) && !pready_i && (to_cnt == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  assign psel_o    = (state == S_SETUP) || (state == S_ACCESS);
  assign penable_o = (state == S_ACCESS);
  assign busy_o    = (state != S_IDLE);

  // Fold in the byte completing this cycle so the last field byte reaches
  // the APB registers on the transition into SETUP.
  assign addr_nx = (state == S_ADDR)  ? {rx_byte, addr_sr[31:8]} : addr_sr;
  assign wd_nx   = (state == S_WDATA) ? {rx_byte, wd_sr[31:8]}   : wd_sr;

  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    tx_data = 8'h00;
    case (state)
      S_IDLE:   if (rx_valid && (rx_byte == 8'h57 || rx_byte == 8'h52)) state_n = S_ADDR;
      S_ADDR:   if (rx_ferr) state_n = S_IDLE;
                else if (rx_valid && byte_cnt == 2'd3) state_n = is_wr ? S_WDATA : S_SETUP;
      S_WDATA:  if (rx_ferr) state_n = S_IDLE;
                else if (rx_valid && byte_cnt == 2'd3) state_n = S_SETUP;
      S_SETUP:  state_n = S_ACCESS;
      S_ACCESS: begin
        // Status byte leaves on the same edge the response is sampled.
        if (pready_i || timeout) begin
          tx_load = 1'b1;
          tx_data = !pready_i ? 8'h54 : (pslverr_i ? 8'h45 : 8'h4B);
          state_n = is_wr ? S_DONE : S_RESP;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          tx_data = rdata_q[{resp_idx, 3'b000} +: 8];
          if (resp_idx == 2'd3) state_n = S_DONE;
        end
      end
      S_DONE:   if (!tx_busy) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE; byte_cnt <= '0; resp_idx <= '0; is_wr <= 1'b0;
      addr_sr <= '0; wd_sr <= '0; rdata_q <= '0;
      paddr_o <= '0; pwdata_o <= '0; pwrite_o <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          if (rx_valid) is_wr <= (rx_byte == 8'h57);
        end
        S_ADDR:  if (rx_valid) begin byte_cnt <= byte_cnt + 1'b1; addr_sr <= addr_nx; end
        S_WDATA: if (rx_valid) begin byte_cnt <= byte_cnt + 1'b1; wd_sr <= wd_nx; end
        S_SETUP: resp_idx <= '0;
        S_ACCESS: begin
          if (pready_i)     rdata_q <= prdata_i;
          else if (timeout) rdata_q <= '0;
        end
        S_RESP:  if (tx_ready) resp_idx <= resp_idx + 1'b1;
        default: ;
      endcase
      if (state_n == S_SETUP && state != S_SETUP) begin
        paddr_o  <= addr_nx[ApbAddrWidth-1:0];
        pwrite_o <= is_wr;
        if (is_wr) pwdata_o <= wd_nx;
      end
    end
  end
endmodule
